prio_encoder_rr: RTL and testbench
==================================

# prio_encoder_rr

Parametrised, registered N-to-log2(N) priority encoder with event capture and a valid/ready output handshake. It is the successor of our fixed 8-to-3 encoder. Input bits are events that are latched into a pending vector and drained one index per handshake, in fixed-priority or round-robin order. It sits between interrupt/request sources and any consumer that services one index at a time, such as a controller FSM or a mux select.

## Interface
Parameters:
- N, 8: number of request inputs; legal range 2..256.
- W, $clog2(N): output index width; derived, not overridden.
- RR_MODE, 0: selects the arbitration order.
  - 0: fixed priority, lowest index wins.
  - 1: round-robin, starting after the last granted index.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- y  input  N  request events; a bit high for one or more cycles sets its pending bit.
- q  output  W  encoded index of the granted request; valid only while q_valid=1.
- q_valid  output  1  q holds an undelivered grant.
- q_ready  input  1  consumer accepts q this cycle when q_valid=1.
- pend  output  N  current pending vector; excludes the index held in q.
- ovf  output  1  one-cycle pulse: an event was lost.

## Operation
Reset values (applied asynchronously while rst=1):
- q=0, q_valid=0, pend=0, ovf=0.
- Round-robin pointer last=N-1, so the first round-robin search begins at index 0.

Per-cycle behaviour:
- Capture: pend_next = (pend & ~take_mask) | y.
  - take_mask is the one-hot of the index loaded into q this cycle, or 0 if none is loaded.
  - If a y bit coincides with the bit being taken, y wins and the bit stays pending. This is a new event.
- Slot free: the output slot is free when q_valid=0, or when q_valid=1 and q_ready=1.
- Load: if the slot is free and pend!=0, load q with the selected index and set q_valid=1. The selected bit moves from pend into q.
- Empty: if the slot is free and pend==0, q_valid goes to 0 and q holds its last value.
- Hold: if q_valid=1 and q_ready=0, q and q_valid hold. Selection is frozen.
- Selection reads the registered pend only; same-cycle y is never selected.
- Fixed mode: select the lowest set index of pend.
- Round-robin mode:
  - Select the lowest set index strictly above last. If there is none, wrap and select the lowest set index overall.
  - last updates to the selected index on every load.
- Overflow: ovf=1 on the cycle after any y bit arrives while its pend bit is already 1 and is not being taken. ovf is the OR over all bits. An event aimed at the index currently held in q is not an overflow; it re-enters pend.
- Reset mid-operation: the pending vector and any held grant are discarded. No ovf is raised.

## Timing
- Latency from event to grant:
  - y high in cycle t sets pend at edge t+1.
  - With the slot free, q_valid=1 at edge t+2. Minimum latency is 2 cycles.
- Throughput: one grant per cycle while q_ready=1 and pend!=0. Back-to-back loads have no bubble.
- q_ready is ignored while q_valid=0.
- Outputs q, q_valid, pend and ovf are registered. There is no combinational path from input to output.
- q stays stable and q_valid stays high from load until the handshake cycle inclusive.

## Structure
- Shared package `enc_pkg`:
  - Mode constants MODE_FIXED=0 and MODE_RR=1.
  - A clog2-style width helper for W on tools without $clog2.
- Sub-module `prio_pick` #(N): purely combinational.
  - Inputs: vector v[N-1:0].
  - Outputs: idx[W-1:0], found.
  - Behaviour: lowest set bit of v.
- Round-robin mode instantiates `prio_pick` twice:
  - once on pend masked to bits above last;
  - once on the unmasked pend.
  - Use the masked result if its found=1, otherwise the unmasked result.
- Fixed mode uses one instance.
- The top level holds the registers: pend, q, q_valid, last, ovf.

## Test plan
- Reset, fixed mode, N=8: pulse y=8'b1000_0001 for 1 cycle with q_ready=1.
  - q=0 with q_valid at cycle t+2, then q=7 at t+3, then q_valid=0.
  - pend returns to 0.
- Backpressure: hold q_ready=0 with q=3 valid, then pulse y[3] again.
  - q stays 3 and ovf stays 0.
  - pend[3]=1.
  - Releasing q_ready delivers 3 twice.
- Overflow: with pend[5]=1 and slot blocked, pulse y[5].
  - ovf=1 for exactly one cycle.
  - pend unchanged.
- Round-robin, N=8: keep y=8'hFF asserted with q_ready=1.
  - Grants are 0,1,…,7,0,1,… with no repeats before wrap.
  - Fixed mode under the same stimulus grants 0 every cycle.
- Simultaneous take and re-arm: y[2] pulses on the same cycle index 2 is loaded into q.
  - pend[2] remains 1.
  - The next grant is 2 again in fixed mode when no lower index is pending.
- Reset mid-operation: assert rst asynchronously between edges while q_valid=1 and pend!=0.
  - Outputs clear immediately.
  - After release, the first round-robin grant is the lowest pending index.

Source files
------------

// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enc_pkg
// Description : Shared constants and helpers for the prio_encoder_rr block.
//               MODE_FIXED / MODE_RR select the arbitration order, and clog2
//               derives the index width on tools lacking $clog2.
// Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Smallest r with 2**r >= value, never less than 1 so a 2-input encoder
  // still gets a 1-bit index.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage : enc_pkg
`default_nettype wire

// File: rtl/prio_encoder_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : prio_pick
// Description : Purely combinational lowest-set-bit finder.
// Ports       : v     [N-1:0] in  - candidate vector
//               idx   [W-1:0] out - index of lowest set bit (0 when none)
//               found         out - at least one bit of v is set
// Revision    : 1.0 - initial release
// ============================================================================
module prio_pick
  import enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] v,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule : prio_pick
`default_nettype wire

// File: rtl/prio_encoder_rr.sv
`default_nettype none
// ============================================================================
// Module      : prio_encoder_rr
// Description : Registered N-to-log2(N) priority encoder with event capture
//               and a valid/ready output handshake. Request events latch into
//               a pending vector and drain one index per handshake, in fixed
//               (lowest index first) or round-robin order.
// Ports       : clk             in  - clock, rising edge
//               rst             in  - asynchronous active-high reset
//               y       [N-1:0] in  - request events
//               q       [W-1:0] out - granted index, valid while q_valid
//               q_valid         out - q holds an undelivered grant
//               q_ready         in  - consumer accepts q this cycle
//               pend    [N-1:0] out - pending vector (excludes index in q)
//               ovf             out - one-cycle pulse: an event was lost
// Revision    : 1.0 - initial release
// ============================================================================
module prio_encoder_rr
  import enc_pkg::*;
#(
  parameter  int N       = 8,
  parameter  int RR_MODE = MODE_FIXED,
  localparam int W       = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] y,
  output logic [W-1:0] q,
  output logic         q_valid,
  input  logic         q_ready,
  output logic [N-1:0] pend,
  output logic         ovf
);

  logic [N-1:0] r_pend;
  logic [W-1:0] r_q;
  logic         r_q_valid;
  logic         r_ovf;

  logic [W-1:0] w_sel;
  logic         w_found;
  logic         w_slot_free;
  logic         w_load;
  logic [N-1:0] w_take;
  logic [N-1:0] w_pend_next;

  // --------------------------------------------------------------------------
  // Index selection (reads registered pend only)
  // --------------------------------------------------------------------------
  generate
    if (RR_MODE == MODE_RR) begin : g_rr
      logic [W-1:0] r_last;
      logic [N-1:0] w_above;
      logic [N-1:0] w_masked;
      logic [W-1:0] w_idx_m;
      logic [W-1:0] w_idx_u;
      logic         w_found_m;
      logic         w_found_u;

      always_comb begin
        w_above = '0;
        for (int i = 0; i < N; i++) begin
          w_above[i] = (i > int'(r_last));
        end
      end

      assign w_masked = r_pend & w_above;

      prio_pick #(.N(N)) u_pick_masked (
        .v     (w_masked),
        .idx   (w_idx_m),
        .found (w_found_m)
      );

      prio_pick #(.N(N)) u_pick_all (
        .v     (r_pend),
        .idx   (w_idx_u),
        .found (w_found_u)
      );

      // Prefer the first pending index after the last grant; otherwise wrap.
      assign w_sel   = w_found_m ? w_idx_m : w_idx_u;
      assign w_found = w_found_u;

      // Reset to N-1 so the first search starts at index 0.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_last <= W'(N - 1);
        end else if (w_load) begin
          r_last <= w_sel;
        end
      end
    end else begin : g_fixed
      prio_pick #(.N(N)) u_pick (
        .v     (r_pend),
        .idx   (w_sel),
        .found (w_found)
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Slot control and capture
  // --------------------------------------------------------------------------
  assign w_slot_free = !r_q_valid || q_ready;
  assign w_load      = w_slot_free && w_found;
  assign w_take      = w_load ? (N'(1) << w_sel) : '0;

  // A y bit on the index being taken re-arms it: OR-ing y last lets it win.
  assign w_pend_next = (r_pend & ~w_take) | y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend    <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_pend <= w_pend_next;
      // Lost event: already pending and not leaving pend this cycle. The
      // index held in q is not in pend, so a hit on it is not counted.
      r_ovf  <= |(y & r_pend & ~w_take);
      if (w_slot_free) begin
        r_q_valid <= w_found;
        if (w_found) r_q <= w_sel;
      end
    end
  end

  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign pend    = r_pend;
  assign ovf     = r_ovf;

endmodule : prio_encoder_rr
`default_nettype wire

// File: tb/tb_prio_encoder_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_prio_encoder_rr
// Description : Self-checking bench driving a fixed-priority and a
//               round-robin instance (N=8) with shared stimulus. A reference
//               model queues expected grants; a monitor pops them on each
//               handshake and compares pend/q_valid/ovf every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prio_encoder_rr;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         q_ready;
  logic [N-1:0] y;

  logic [W-1:0] q_f, q_r;
  logic         qv_f, qv_r;
  logic [N-1:0] pend_f, pend_r;
  logic         ovf_f, ovf_r;

  always #5 clk = ~clk;

  prio_encoder_rr #(.N(N), .RR_MODE(0)) u_dut_fixed (
    .clk     (clk),
    .rst     (rst),
    .y       (y),
    .q       (q_f),
    .q_valid (qv_f),
    .q_ready (q_ready),
    .pend    (pend_f),
    .ovf     (ovf_f)
  );

  prio_encoder_rr #(.N(N), .RR_MODE(1)) u_dut_rr (
    .clk     (clk),
    .rst     (rst),
    .y       (y),
    .q       (q_r),
    .q_valid (qv_r),
    .q_ready (q_ready),
    .pend    (pend_r),
    .ovf     (ovf_r)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: index 0 = fixed, index 1 = round-robin
  // --------------------------------------------------------------------------
  logic [N-1:0] m_pend  [2];
  logic         m_valid [2];
  logic         m_ovf   [2];
  int           m_last  [2];
  int           eq0[$];
  int           eq1[$];

  always @(posedge clk or posedge rst) begin : model
    int take;
    int idx;
    bit free;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_pend[d]  = '0;
        m_valid[d] = 1'b0;
        m_ovf[d]   = 1'b0;
        m_last[d]  = N - 1;
      end
      eq0.delete();
      eq1.delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        take = -1;
        free = !m_valid[d] || q_ready;
        if (free) begin
          for (int k = 1; k <= N; k++) begin
            idx = (d == 1) ? (m_last[d] + k) % N : k - 1;
            if (take < 0 && m_pend[d][idx]) take = idx;
          end
          if (take >= 0) begin
            m_valid[d] = 1'b1;
            m_last[d]  = take;
            if (d == 0) eq0.push_back(take);
            else        eq1.push_back(take);
          end else begin
            m_valid[d] = 1'b0;
          end
        end
        m_ovf[d] = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (y[i] && m_pend[d][i] && i != take) m_ovf[d] = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
          if (i == take) m_pend[d][i] = y[i];
          else           m_pend[d][i] = m_pend[d][i] | y[i];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  always @(negedge clk) begin : monitor
    int e;
    chk("qv_fixed",   32'(qv_f),   32'(m_valid[0]));
    chk("pend_fixed", 32'(pend_f), 32'(m_pend[0]));
    chk("ovf_fixed",  32'(ovf_f),  32'(m_ovf[0]));
    chk("qv_rr",      32'(qv_r),   32'(m_valid[1]));
    chk("pend_rr",    32'(pend_r), 32'(m_pend[1]));
    chk("ovf_rr",     32'(ovf_r),  32'(m_ovf[1]));
    if (qv_f) begin
      if (eq0.size() == 0) begin
        chk("grant_fixed_queue", 32'(q_f), 32'hFFFF_FFFF);
      end else begin
        e = eq0[0];
        chk("grant_fixed", 32'(q_f), 32'(e));
        if (q_ready) void'(eq0.pop_front());
      end
    end
    if (qv_r) begin
      if (eq1.size() == 0) begin
        chk("grant_rr_queue", 32'(q_r), 32'hFFFF_FFFF);
      end else begin
        e = eq1[0];
        chk("grant_rr", 32'(q_r), 32'(e));
        if (q_ready) void'(eq1.pop_front());
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus: inputs live for exactly one rising edge per call
  // --------------------------------------------------------------------------
  task automatic cyc(input logic [N-1:0] yv, input logic rdy);
    y       = yv;
    q_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic random_run(input int n);
    logic [N-1:0] yr;
    for (int i = 0; i < n; i++) begin
      yr = N'($urandom) & N'($urandom) & N'($urandom);
      cyc(yr, $urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    rst     = 1'b1;
    y       = '0;
    q_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q",    32'(q_f),    32'd0);
    chk("reset_qv",   32'(qv_f),   32'd0);
    chk("reset_pend", 32'(pend_r), 32'd0);
    chk("reset_ovf",  32'(ovf_r),  32'd0);
    rst = 1'b0;
    #1;

    // Two events in one pulse: fixed delivers 0 then 7.
    cyc(8'h81, 1'b1);
    repeat (5) cyc('0, 1'b1);

    // Backpressure, re-arm of the held index, then overflow on index 5.
    cyc(8'h08, 1'b0);
    cyc(8'h20, 1'b0);
    cyc(8'h08, 1'b0);
    chk("hold_q",    32'(q_f),    32'd3);
    chk("hold_qv",   32'(qv_f),   32'd1);
    chk("hold_pend", 32'(pend_f), 32'h28);
    chk("hold_ovf",  32'(ovf_f),  32'd0);
    cyc(8'h20, 1'b0);
    chk("ovf_pulse",      32'(ovf_f),  32'd1);
    chk("ovf_pulse_rr",   32'(ovf_r),  32'd1);
    chk("ovf_pend_keep",  32'(pend_f), 32'h28);
    cyc('0, 1'b0);
    chk("ovf_one_cycle",  32'(ovf_f),  32'd0);
    repeat (6) cyc('0, 1'b1);

    // Continuous all-ones request.
    repeat (20) cyc(8'hFF, 1'b1);
    repeat (12) cyc('0, 1'b1);

    // Re-arm on the same cycle index 2 is taken.
    cyc(8'h04, 1'b1);
    cyc(8'h04, 1'b1);
    chk("rearm_q",    32'(q_f),    32'd2);
    chk("rearm_pend", 32'(pend_f), 32'h04);
    cyc('0, 1'b1);
    chk("rearm_again", 32'(q_f),  32'd2);
    chk("rearm_qv",    32'(qv_f), 32'd1);
    repeat (4) cyc('0, 1'b1);

    random_run(400);

    // Asynchronous reset between edges with a held grant and pending bits.
    cyc(8'hF0, 1'b0);
    cyc(8'h0F, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("areset_qv_f",   32'(qv_f),   32'd0);
    chk("areset_pend_f", 32'(pend_f), 32'd0);
    chk("areset_qv_r",   32'(qv_r),   32'd0);
    chk("areset_pend_r", 32'(pend_r), 32'd0);
    chk("areset_q_r",    32'(q_r),    32'd0);
    @(posedge clk);
    #1;
    chk("areset_ovf", 32'(ovf_f), 32'd0);
    rst = 1'b0;
    #1;
    cyc(8'h24, 1'b1);
    cyc('0, 1'b1);
    chk("rr_after_reset", 32'(q_r),  32'd2);
    chk("rr_after_rst_v", 32'(qv_r), 32'd1);
    cyc('0, 1'b1);
    chk("rr_second", 32'(q_r), 32'd5);

    random_run(400);
    repeat (12) cyc('0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_prio_encoder_rr
`default_nettype wire
